// File: rtl/lsu.sv
// Load/store unit: one word-wide memory transaction per request with a valid/ack
// handshake, byte-lane store steering, load extraction and misalignment trapping.
module lsu #(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    // Upstream handshake: a request transfers on the rising edge where
    // req_valid && req_ready; the requester holds all req_* stable until then.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [RD_W-1:0]   resp_rd,
    output logic              resp_misalign,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [RD_W-1:0]   resp_rd_q, resp_rd_d;
    logic              resp_misalign_q, resp_misalign_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        off_q, off_d;

    logic              misaligned;
    logic [1:0]        req_off;
    logic [3:0]        req_be;
    logic [31:0]       req_lanes;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

    assign req_off = req_addr[1:0];

    always_comb begin
        misaligned = 1'b0;
        req_be     = 4'b1111;
        req_lanes  = req_wdata;
        case (req_size)
            2'b00: begin
                req_be    = 4'b0001 << req_off;
                req_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_off[0];
                req_be     = 4'b0011 << req_off;
                req_lanes  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = (req_off != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Load extraction works on the offset/size latched at accept time.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_data = {{24{ld_byte[7] & ~unsigned_q}}, ld_byte};
            2'b01:   ld_data = {{16{ld_half[15] & ~unsigned_q}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_be_d        = mem_be_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = resp_data_q;
        resp_rd_d       = resp_rd_q;
        resp_misalign_d = resp_misalign_q;
        rd_d            = rd_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        off_d           = off_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_d       = req_rd;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    off_d      = req_off;
                    if (misaligned) begin
                        // Faulting access never reaches memory.
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_misalign_d = 1'b1;
                        resp_data_d     = 32'd0;
                        resp_rd_d       = '0;
                    end else begin
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = req_lanes;
                        mem_be_d    = req_be;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d         = RESP;
                    mem_req_d       = 1'b0;
                    mem_we_d        = 1'b0;
                    mem_be_d        = 4'b0000;
                    resp_valid_d    = 1'b1;
                    resp_misalign_d = 1'b0;
                    resp_data_d     = mem_we_q ? 32'd0 : ld_data;
                    resp_rd_d       = mem_we_q ? '0 : rd_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= 32'd0;
            mem_be_q        <= 4'b0000;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= 32'd0;
            resp_rd_q       <= '0;
            resp_misalign_q <= 1'b0;
            rd_q            <= '0;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            off_q           <= 2'b00;
        end else begin
            state_q         <= state_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_be_q        <= mem_be_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_rd_q       <= resp_rd_d;
            resp_misalign_q <= resp_misalign_d;
            rd_q            <= rd_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            off_q           <= off_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_rd       = resp_rd_q;
    assign resp_misalign = resp_misalign_q;
    assign dbg_state     = state_q;

endmodule
